// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with scoreboard busy bits, write forwarding and debug port
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] wd,
    input  logic            wb_clr,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] rs2_val,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            hazard,
    output logic [AW:0]     busy_cnt,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_val
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;

    logic            wr_live;
    logic            set_req;
    logic            clr_req;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic            cnt_inc;
    logic            cnt_dec;

    assign wr_live  = we && (rd != '0);
    assign set_req  = issue_valid && (issue_rd != '0);
    assign clr_req  = wr_live && wb_clr;
    assign set_mask = set_req ? (NREG'(1) << issue_rd) : '0;
    assign clr_mask = clr_req ? (NREG'(1) << rd) : '0;

    // A clear that collides with a new issue of the same register is cancelled.
    assign cnt_inc = set_req && !busy[issue_rd];
    assign cnt_dec = clr_req && busy[rd] && !(set_req && (issue_rd == rd));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[rd] <= wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= (busy & ~clr_mask) | set_mask;
            busy_cnt <= busy_cnt + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
        end
    end

    // Forwarding is gated by rst_n so reads stay zero while reset is held.
    always_comb begin
        rs1_val  = regs[rs1];
        rs2_val  = regs[rs2];
        rs1_busy = busy[rs1];
        rs2_busy = busy[rs2];
        if (BYPASS != 0 && rst_n && wr_live) begin
            if (rs1 == rd) begin
                rs1_val  = wd;
                rs1_busy = busy[rs1] && !wb_clr;
            end
            if (rs2 == rd) begin
                rs2_val  = wd;
                rs2_busy = busy[rs2] && !wb_clr;
            end
        end
    end

    assign hazard  = rs1_busy || rs2_busy;
    assign dbg_val = regs[dbg_addr];

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - randomized and directed bench for regfile_sb against a behavioural model
module tb_regfile_sb;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            we = 1'b0, wb_clr = 1'b0, issue_valid = 1'b0;
    logic [AW-1:0]   rd = '0, issue_rd = '0, rs1 = '0, rs2 = '0, dbg_addr = '0;
    logic [XLEN-1:0] wd = '0;

    logic [XLEN-1:0] rs1_val, rs2_val, dbg_val;
    logic            rs1_busy, rs2_busy, hazard;
    logic [AW:0]     busy_cnt;
    logic [XLEN-1:0] n_rs1_val, n_rs2_val, n_dbg_val;
    logic            n_rs1_busy, n_rs2_busy, n_hazard;
    logic [AW:0]     n_busy_cnt;

    int tot = 0;
    int bad = 0;

    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .rd(rd), .wd(wd), .wb_clr(wb_clr),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .hazard(hazard), .busy_cnt(busy_cnt), .dbg_addr(dbg_addr), .dbg_val(dbg_val)
    );

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .we(we), .rd(rd), .wd(wd), .wb_clr(wb_clr),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
        .rs1_val(n_rs1_val), .rs2_val(n_rs2_val), .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy),
        .hazard(n_hazard), .busy_cnt(n_busy_cnt), .dbg_addr(dbg_addr), .dbg_val(n_dbg_val)
    );

    function automatic void model_clear();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic logic [AW:0] model_count();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
        return (AW+1)'(n);
    endfunction

    function automatic logic [XLEN-1:0] model_read(input logic [AW-1:0] a, input bit fwd);
        if (a == 0) return '0;
        if (fwd && rst_n && we && rd == a) return wd;
        return m_regs[a];
    endfunction

    function automatic bit model_busy(input logic [AW-1:0] a, input bit fwd);
        if (fwd && rst_n && we && wb_clr && rd == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            if (we && rd != 0) m_regs[rd] = wd;
            if (we && wb_clr) m_busy[rd] = 1'b0;
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        we = 1'b0; wb_clr = 1'b0; issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        model_clear();
        rst_n = 1'b0;
        idle();
        step();
        for (int a = 0; a < NREG; a++) begin
            rs1 = AW'(a); rs2 = AW'(a); dbg_addr = AW'(a);
            #1;
            tot += 3;
            if (rs1_val !== '0) begin bad++; $display("FAIL reset_rs1 a=%0d got=%h exp=0", a, rs1_val); end
            if (rs2_val !== '0) begin bad++; $display("FAIL reset_rs2 a=%0d got=%h exp=0", a, rs2_val); end
            if (dbg_val !== '0) begin bad++; $display("FAIL reset_dbg a=%0d got=%h exp=0", a, dbg_val); end
        end
        we = 1'b1; rd = 5'd3; wd = 32'hDEAD_BEEF; rs1 = 5'd3; issue_valid = 1'b1; issue_rd = 5'd3;
        #1;
        tot++;
        if (rs1_val !== '0) begin bad++; $display("FAIL reset_fwd got=%h exp=0", rs1_val); end
        step();
        tot += 3;
        if (hazard !== 1'b0) begin bad++; $display("FAIL reset_hazard got=%b exp=0", hazard); end
        if (busy_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", busy_cnt); end
        if (rs1_val !== '0) begin bad++; $display("FAIL reset_wr_ignored got=%h exp=0", rs1_val); end
        idle();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_bypass();
        we = 1'b1; rd = 5'd5; wd = 32'h1F; rs1 = 5'd5;
        #1;
        tot += 2;
        if (rs1_val !== 32'h1F) begin bad++; $display("FAIL byp_same got=%h exp=1f", rs1_val); end
        if (n_rs1_val !== 32'h0) begin bad++; $display("FAIL nobyp_old got=%h exp=0", n_rs1_val); end
        step();
        idle();
        #1;
        tot += 2;
        if (rs1_val !== 32'h1F) begin bad++; $display("FAIL byp_stored got=%h exp=1f", rs1_val); end
        if (n_rs1_val !== 32'h1F) begin bad++; $display("FAIL nobyp_next got=%h exp=1f", n_rs1_val); end
        we = 1'b1; rd = 5'd9; wd = 32'hA5; rs1 = 5'd9;
        #1;
        tot += 2;
        if (n_rs1_val !== 32'h0) begin bad++; $display("FAIL nobyp_x9_old got=%h exp=0", n_rs1_val); end
        if (rs1_val !== 32'hA5) begin bad++; $display("FAIL byp_x9 got=%h exp=a5", rs1_val); end
        step();
        idle();
        #1;
        tot++;
        if (n_rs1_val !== 32'hA5) begin bad++; $display("FAIL nobyp_x9_next got=%h exp=a5", n_rs1_val); end
        we = 1'b1; rd = 5'd0; wd = 32'hFFFF_FFFF; rs1 = 5'd0;
        #1;
        tot++;
        if (rs1_val !== '0) begin bad++; $display("FAIL x0_fwd got=%h exp=0", rs1_val); end
        step();
        idle();
        dbg_addr = 5'd0;
        #1;
        tot += 2;
        if (rs1_val !== '0) begin bad++; $display("FAIL x0_read got=%h exp=0", rs1_val); end
        if (dbg_val !== '0) begin bad++; $display("FAIL x0_dbg got=%h exp=0", dbg_val); end
    endtask

    task automatic test_busy();
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        idle();
        rs1 = 5'd5; rs2 = 5'd7;
        #1;
        tot += 3;
        if (rs2_busy !== 1'b1) begin bad++; $display("FAIL busy_set got=%b exp=1", rs2_busy); end
        if (hazard !== 1'b1) begin bad++; $display("FAIL busy_hazard got=%b exp=1", hazard); end
        if (busy_cnt !== 6'd1) begin bad++; $display("FAIL busy_cnt1 got=%0d exp=1", busy_cnt); end
        we = 1'b1; wb_clr = 1'b1; rd = 5'd7; wd = 32'd42;
        #1;
        tot += 4;
        if (rs2_busy !== 1'b0) begin bad++; $display("FAIL wb_byp_busy got=%b exp=0", rs2_busy); end
        if (rs2_val !== 32'd42) begin bad++; $display("FAIL wb_byp_val got=%0d exp=42", rs2_val); end
        if (hazard !== 1'b0) begin bad++; $display("FAIL wb_hazard got=%b exp=0", hazard); end
        if (n_rs2_busy !== 1'b1) begin bad++; $display("FAIL nobyp_busy got=%b exp=1", n_rs2_busy); end
        step();
        idle();
        #1;
        tot += 2;
        if (busy_cnt !== 6'd0) begin bad++; $display("FAIL wb_cnt0 got=%0d exp=0", busy_cnt); end
        if (rs2_busy !== 1'b0) begin bad++; $display("FAIL wb_busy_after got=%b exp=0", rs2_busy); end
    endtask

    task automatic test_set_clear();
        issue_valid = 1'b1; issue_rd = 5'd3;
        step();
        we = 1'b1; wb_clr = 1'b1; rd = 5'd3; wd = 32'h33;
        step();
        idle();
        rs1 = 5'd3; rs2 = 5'd4;
        #1;
        tot += 2;
        if (rs1_busy !== 1'b1) begin bad++; $display("FAIL same_busy got=%b exp=1", rs1_busy); end
        if (busy_cnt !== 6'd1) begin bad++; $display("FAIL same_cnt got=%0d exp=1", busy_cnt); end
        issue_valid = 1'b1; issue_rd = 5'd4; we = 1'b1; wb_clr = 1'b1; rd = 5'd3;
        step();
        idle();
        #1;
        tot += 3;
        if (rs1_busy !== 1'b0) begin bad++; $display("FAIL diff_clr got=%b exp=0", rs1_busy); end
        if (rs2_busy !== 1'b1) begin bad++; $display("FAIL diff_set got=%b exp=1", rs2_busy); end
        if (busy_cnt !== 6'd1) begin bad++; $display("FAIL diff_cnt got=%0d exp=1", busy_cnt); end
        issue_valid = 1'b1; issue_rd = 5'd4;
        step();
        we = 1'b1; wb_clr = 1'b1; rd = 5'd9; issue_valid = 1'b0;
        step();
        idle();
        #1;
        tot++;
        if (busy_cnt !== 6'd1) begin bad++; $display("FAIL rebusy_noop_cnt got=%0d exp=1", busy_cnt); end
        we = 1'b1; wb_clr = 1'b1; rd = 5'd4;
        step();
        idle();
        #1;
        tot++;
        if (busy_cnt !== 6'd0) begin bad++; $display("FAIL final_clr_cnt got=%0d exp=0", busy_cnt); end
    endtask

    task automatic test_fill_and_reset();
        for (int i = 1; i < NREG; i++) begin
            issue_valid = 1'b1; issue_rd = AW'(i);
            step();
        end
        idle();
        rs1 = 5'd5; rs2 = 5'd31;
        #1;
        tot += 2;
        if (busy_cnt !== 6'd31) begin bad++; $display("FAIL fill_cnt got=%0d exp=31", busy_cnt); end
        if (hazard !== 1'b1) begin bad++; $display("FAIL fill_hazard got=%b exp=1", hazard); end
        #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        tot += 4;
        if (busy_cnt !== 6'd0) begin bad++; $display("FAIL async_cnt got=%0d exp=0", busy_cnt); end
        if (n_busy_cnt !== 6'd0) begin bad++; $display("FAIL async_cnt_nb got=%0d exp=0", n_busy_cnt); end
        if (hazard !== 1'b0) begin bad++; $display("FAIL async_hazard got=%b exp=0", hazard); end
        if (rs1_val !== '0) begin bad++; $display("FAIL async_regs got=%h exp=0", rs1_val); end
        we = 1'b1; rd = 5'd8; wd = 32'h77; dbg_addr = 5'd8;
        step();
        tot++;
        if (dbg_val !== '0) begin bad++; $display("FAIL rst_wr_ignored got=%h exp=0", dbg_val); end
        idle();
        rst_n = 1'b1;
        we = 1'b1; rd = 5'd8; wd = 32'h1234;
        step();
        idle();
        #1;
        tot += 2;
        if (dbg_val !== 32'h1234) begin bad++; $display("FAIL post_rst_wr got=%h exp=1234", dbg_val); end
        if (busy_cnt !== 6'd0) begin bad++; $display("FAIL post_rst_cnt got=%0d exp=0", busy_cnt); end
    endtask

    task automatic test_random();
        logic [AW:0] ecnt;
        logic [XLEN-1:0] e1, e2;
        bit b1, b2;
        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom); wb_clr = 1'($urandom_range(0, 3) != 0);
            issue_valid = 1'($urandom_range(0, 2) != 0);
            rd = AW'($urandom); issue_rd = AW'($urandom); wd = $urandom;
            rs1 = AW'($urandom); rs2 = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom);
            dbg_addr = AW'($urandom);
            #1;
            ecnt = model_count();
            e1 = model_read(rs1, 1'b1); e2 = model_read(rs2, 1'b1);
            b1 = model_busy(rs1, 1'b1); b2 = model_busy(rs2, 1'b1);
            tot += 11;
            if (rs1_val !== e1) begin bad++; $display("FAIL rnd_rs1 n=%0d got=%h exp=%h", n, rs1_val, e1); end
            if (rs2_val !== e2) begin bad++; $display("FAIL rnd_rs2 n=%0d got=%h exp=%h", n, rs2_val, e2); end
            if (rs1_busy !== b1) begin bad++; $display("FAIL rnd_b1 n=%0d got=%b exp=%b", n, rs1_busy, b1); end
            if (rs2_busy !== b2) begin bad++; $display("FAIL rnd_b2 n=%0d got=%b exp=%b", n, rs2_busy, b2); end
            if (hazard !== (b1 | b2)) begin bad++; $display("FAIL rnd_hz n=%0d got=%b exp=%b", n, hazard, b1 | b2); end
            if (busy_cnt !== ecnt) begin bad++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, busy_cnt, ecnt); end
            if (dbg_val !== model_read(dbg_addr, 1'b0)) begin bad++; $display("FAIL rnd_dbg n=%0d got=%h exp=%h", n, dbg_val, model_read(dbg_addr, 1'b0)); end
            if (n_rs1_val !== model_read(rs1, 1'b0)) begin bad++; $display("FAIL rnd_nb_rs1 n=%0d got=%h exp=%h", n, n_rs1_val, model_read(rs1, 1'b0)); end
            if (n_rs2_val !== model_read(rs2, 1'b0)) begin bad++; $display("FAIL rnd_nb_rs2 n=%0d got=%h exp=%h", n, n_rs2_val, model_read(rs2, 1'b0)); end
            if (n_rs2_busy !== model_busy(rs2, 1'b0)) begin bad++; $display("FAIL rnd_nb_b2 n=%0d got=%b exp=%b", n, n_rs2_busy, model_busy(rs2, 1'b0)); end
            if (n_busy_cnt !== ecnt) begin bad++; $display("FAIL rnd_nb_cnt n=%0d got=%0d exp=%0d", n, n_busy_cnt, ecnt); end
            step();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_busy();
        test_set_clear();
        test_fill_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
